// File: rtl/mul_pipe_if.sv
// Issue/writeback handshake bundle for the pipelined multiply stage.
// master = issue/writeback side, slave = mul_pipe.
interface mul_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_funct3, in_a, in_b, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_data, out_tag, busy
    );

    modport slave (
        input  in_valid, in_funct3, in_a, in_b, in_tag, flush, out_ready,
        output in_ready, out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/mul_pipe.sv
// Two-stage MUL/MULH/MULHSU/MULHU execution stage: S1 holds decoded operands
// feeding the combinational multiplier, S2 holds the selected tagged result.
module mul_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_pipe_if.slave  bus
);
    localparam int unsigned PROD_W = 2 * XLEN;
    localparam int unsigned EXT_W  = PROD_W + 2;

    typedef enum logic [1:0] {
        MODE_UU = 2'b00,
        MODE_SU = 2'b01,
        MODE_SS = 2'b10
    } mode_e;

    logic             s1_valid;
    logic [XLEN-1:0]  s1_a;
    logic [XLEN-1:0]  s1_b;
    mode_e            s1_mode;
    logic             s1_high;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [XLEN-1:0]  s2_data;
    logic [TAG_W-1:0] s2_tag;

    mode_e            dec_mode;
    logic             dec_high;
    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic             consume;

    logic                    a_sgn;
    logic                    b_sgn;
    logic signed [XLEN:0]    a_ext;
    logic signed [XLEN:0]    b_ext;
    logic signed [EXT_W-1:0] prod_full;
    logic [PROD_W-1:0]       prod;
    logic [XLEN-1:0]         result;
    logic                    unused_bits;

    // Opcode decode; the low word is sign-agnostic, MUL rides the s*s mode.
    always_comb begin
        dec_mode = MODE_SS;
        dec_high = 1'b1;
        case (bus.in_funct3[1:0])
            2'b00:   begin dec_mode = MODE_SS; dec_high = 1'b0; end
            2'b01:   begin dec_mode = MODE_SS; dec_high = 1'b1; end
            2'b10:   begin dec_mode = MODE_SU; dec_high = 1'b1; end
            default: begin dec_mode = MODE_UU; dec_high = 1'b1; end
        endcase
    end

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_adv;
    assign bus.in_ready = !bus.flush && (!s1_valid || s2_adv);
    assign accept       = bus.in_valid && bus.in_ready;
    assign consume      = s2_valid && bus.out_ready;

    // 32x32 multiplier core: operands widened by one bit carrying the sign mode.
    assign a_sgn     = (s1_mode == MODE_SU) || (s1_mode == MODE_SS);
    assign b_sgn     = (s1_mode == MODE_SS);
    assign a_ext     = $signed({a_sgn & s1_a[XLEN-1], s1_a});
    assign b_ext     = $signed({b_sgn & s1_b[XLEN-1], s1_b});
    assign prod_full = EXT_W'(a_ext) * EXT_W'(b_ext);
    assign prod      = prod_full[PROD_W-1:0];
    assign result    = s1_high ? prod[PROD_W-1:XLEN] : prod[XLEN-1:0];

    assign unused_bits = ^{bus.in_funct3[2], prod_full[EXT_W-1:PROD_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= MODE_UU;
            s1_high  <= 1'b0;
            s1_tag   <= '0;
        end else if (bus.flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.in_a;
            s1_b     <= bus.in_b;
            s1_mode  <= dec_mode;
            s1_high  <= dec_high;
            s1_tag   <= bus.in_tag;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Result register holds its word and tag while writeback stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
        end else if (bus.flush) begin
            s2_valid <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_data  <= result;
            s2_tag   <= s1_tag;
        end else if (consume) begin
            s2_valid <= 1'b0;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_tag   = s2_tag;
    assign bus.busy      = s1_valid | s2_valid;
endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: accepted ops push expected results, the
// writeback monitor pops and compares data, tag and latency.
module tb_mul_pipe;
    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic chk_lat = 1'b1;
    logic [31:0] cur_exp = '0;
    exp_t sb[$];
    exp_t e;

    mul_pipe_if #(.XLEN(32), .TAG_W(5)) bus ();

    mul_pipe #(.XLEN(32), .TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Writeback monitor sampled mid-cycle; flush discards everything in flight.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.flush) begin
                sb.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", 64'(bus.out_tag), 64'hdead);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 64'(bus.out_data), 64'(e.data));
                        check("out_tag", 64'(bus.out_tag), 64'(e.tag));
                        if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
                    end
                end
                if (bus.in_valid && bus.in_ready)
                    sb.push_back('{cur_exp, bus.in_tag, cyc});
            end
        end
    end

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb_;
        logic [63:0] ua, ub, p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (f[1:0])
            2'b00:   p = ua * ub;
            2'b01:   p = 64'(sa * sb_);
            2'b10:   p = 64'(sa * longint'(ub));
            default: p = ua * ub;
        endcase
        return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, output int waits);
        waits         = 0;
        cur_exp       = exp;
        bus.in_funct3 = f;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tag;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("issue_timeout", 64'(waits), 64'd0);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) return;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    int w;
    logic [31:0] bp_exp0;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_funct3 = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #7;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic ops one at a time
        issue(F_MUL, 32'h0001_0000, 32'h0001_0000, 5'd1, 32'h0000_0000, w); wait_drain();
        issue(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, w); wait_drain();
        issue(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, w); wait_drain();
        issue(F_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, w); wait_drain();
        issue(F_MULH, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, w); wait_drain();
        issue(3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd6,
              model(3'b111, 32'h1234_5678, 32'h9ABC_DEF0), w); wait_drain();
        issue(F_MULHSU, 32'h8000_0001, 32'hFFFF_0000, 5'd7,
              model(F_MULHSU, 32'h8000_0001, 32'hFFFF_0000), w); wait_drain();
        @(posedge clk);
        #1;

        // Streaming: back-to-back, in_ready must never drop
        for (int i = 0; i < 8; i++) begin
            issue(F_MUL, 32'(i), 32'd3, 5'(i), 32'(i * 3), w);
            check("stream_wait", 64'(w), 64'd0);
        end
        wait_drain();

        // Backpressure: two accepted, then stall with frozen output
        chk_lat       = 1'b0;
        bus.out_ready = 1'b0;
        bp_exp0       = model(F_MUL, 32'd100, 32'd5);
        issue(F_MUL, 32'd100, 32'd5, 5'd10, bp_exp0, w);
        issue(F_MULH, 32'hF000_0000, 32'd101, 5'd11, model(F_MULH, 32'hF000_0000, 32'd101), w);
        cur_exp       = model(F_MULHU, 32'hDEAD_BEEF, 32'd102);
        bus.in_funct3 = F_MULHU;
        bus.in_a      = 32'hDEAD_BEEF;
        bus.in_b      = 32'd102;
        bus.in_tag    = 5'd12;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_out_data", 64'(bus.out_data), 64'(bp_exp0));
            check("bp_out_tag", 64'(bus.out_tag), 64'd10);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        issue(F_MUL, 32'hFFFF_FFFF, 32'd7, 5'd13, model(F_MUL, 32'hFFFF_FFFF, 32'd7), w);
        wait_drain();
        @(posedge clk);
        #1;
        chk_lat = 1'b1;

        // Flush with two in flight; op offered during flush must be refused
        issue(F_MUL, 32'd11, 32'd12, 5'd14, 32'd132, w);
        issue(F_MUL, 32'd13, 32'd14, 5'd15, 32'd182, w);
        bus.flush     = 1'b1;
        cur_exp       = 32'd999;
        bus.in_funct3 = F_MUL;
        bus.in_a      = 32'd33;
        bus.in_b      = 32'd3;
        bus.in_tag    = 5'd20;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        issue(F_MULHU, 32'h0000_0002, 32'h8000_0000, 5'd21, 32'h0000_0001, w);
        wait_drain();
        @(posedge clk);
        #1;

        // Async reset mid-cycle with a stalled result on the output
        chk_lat       = 1'b0;
        bus.out_ready = 1'b0;
        issue(F_MUL, 32'd5, 32'd9, 5'd3, 32'd45, w);
        issue(F_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'd1, w);
        #2;
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        check("pre_rst_out_data", 64'(bus.out_data), 64'd45);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_out_data", 64'(bus.out_data), 64'd0);
        check("async_rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("async_rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk_lat = 1'b1;
        issue(F_MUL, 32'd7, 32'd6, 5'd9, 32'd42, w);
        wait_drain();

        repeat (4) @(posedge clk);
        #2;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
